// File: rtl/instruction_encoder.sv
// ============================================================================
// instruction_encoder
//
// Purpose:
//   Turns an encode request (instruction class plus operand fields) into a
//   32-bit instruction word. Each word is tagged with an 8-bit
//   instruction-memory address and queued in a 4-entry FIFO.
//
//   Fields are numbered big-endian: bit 0 is the MSB. The vectors below use
//   descending ranges, so big-endian bit k is index (W-1-k). For example,
//   big-endian alu_op[1] is in_alu_op[4] here.
//
//   Word layout, MSB first:
//     opcode[0:5] rD[6:10] rA[11:15] rB[16:20] ppp[21:23] ww[24:25]
//     alu_op[26:31]
//   For memory and branch classes, imm occupies [16:31].
//
// Configuration:
//   ENC_LEGALIZE_EN (undefined by default)
//     When defined, the block forces rB to 0 for ALU ops that do not read
//     rB. It also raises a one-cycle err pulse when it accepts an illegal
//     class.
//     Illegal classes always encode as NOP, whether or not the macro is
//     defined.
//
// Ports:
//   clk         single clock, rising edge
//   reset       asynchronous, active-low reset
//   in_valid    encode request present
//   in_ready    request accepted when in_valid & in_ready at posedge
//   in_class    000 NOP, 001 ALU, 010 LD, 011 SD, 100 BEZ, 101 BNEZ,
//               110/111 illegal
//   in_rD/rA/rB register fields
//   in_alu_op, in_ppp, in_ww, in_imm   operand fields
//   addr_load   load the address counter with addr_value
//   addr_value  new address counter value
//   out_valid   FIFO head holds an encoded word
//   out_ready   consumer pops the head when out_valid & out_ready
//   out_instr   encoded word at the FIFO head (holds last value when empty)
//   out_addr    address tag of the head word
//   err         one-cycle pulse after an illegal request is accepted
// ============================================================================
module instruction_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_class,
    input  logic [4:0]  in_rD,
    input  logic [4:0]  in_rA,
    input  logic [4:0]  in_rB,
    input  logic [5:0]  in_alu_op,
    input  logic [2:0]  in_ppp,
    input  logic [1:0]  in_ww,
    input  logic [15:0] in_imm,
    input  logic        addr_load,
    input  logic [7:0]  addr_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [7:0]  out_addr,
    output logic        err
);

    localparam logic [5:0] OPC_ALU  = 6'b101010;
    localparam logic [5:0] OPC_LD   = 6'b100000;
    localparam logic [5:0] OPC_SD   = 6'b100001;
    localparam logic [5:0] OPC_BEZ  = 6'b100010;
    localparam logic [5:0] OPC_BNEZ = 6'b100011;
    localparam logic [5:0] OPC_NOP  = 6'b111100;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [39:0] fifo_mem [4];          // {word, addr tag}
    logic [1:0]  wr_ptr_q, rd_ptr_q;
    logic [2:0]  count_q, count_d;
    logic        ready_en_q;            // keeps in_ready low until first edge after reset
    logic [7:0]  addr_q, addr_d;
    logic [31:0] out_instr_q;
    logic [7:0]  out_addr_q;
    logic        head_load;
    logic [39:0] head_d;
    logic        err_q, err_d;

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    logic accept, pop;
    logic [7:0] tag;
    logic [1:0] rd_ptr_inc;

    assign in_ready   = ready_en_q & (count_q < 3'd4);
    assign out_valid  = (count_q != 3'd0);
    assign accept     = in_valid & in_ready;
    assign pop        = out_valid & out_ready;
    assign rd_ptr_inc = rd_ptr_q + 2'd1;

    // A same-cycle load wins over the stored counter value.
    assign tag = addr_load ? addr_value : addr_q;

    // ------------------------------------------------------------------
    // Optional legalization
    // ------------------------------------------------------------------
    logic rb_zero;
    logic illegal;

`ifdef ENC_LEGALIZE_EN
    // These ALU ops do not read rB: 000100, 000101, 001101, and any op
    // with big-endian bit 1 set.
    assign rb_zero = (in_alu_op == 6'b000100) | (in_alu_op == 6'b000101) |
                     (in_alu_op == 6'b001101) | in_alu_op[4];
    assign illegal = in_class[2] & in_class[1];
`else
    assign rb_zero = 1'b0;
    assign illegal = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Encoder
    // ------------------------------------------------------------------
    logic [31:0] enc_word;
    logic [4:0]  rb_eff;

    assign rb_eff = rb_zero ? 5'd0 : in_rB;

    always_comb begin
        enc_word = {OPC_NOP, 26'd0};
        case (in_class)
            3'b001:  enc_word = {OPC_ALU, in_rD, in_rA, rb_eff, in_ppp, in_ww, in_alu_op};
            3'b010:  enc_word = {OPC_LD,   in_rD, 5'd0, in_imm};
            3'b011:  enc_word = {OPC_SD,   in_rD, 5'd0, in_imm};
            3'b100:  enc_word = {OPC_BEZ,  in_rD, 5'd0, in_imm};
            3'b101:  enc_word = {OPC_BNEZ, in_rD, 5'd0, in_imm};
            default: enc_word = {OPC_NOP, 26'd0};   // NOP and illegal classes
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        count_d = count_q + {2'd0, accept} - {2'd0, pop};

        addr_d = addr_q;
        if (accept)
            addr_d = tag + 8'd1;
        else if (addr_load)
            addr_d = addr_value;

        err_d = accept & illegal;

        // The registered head follows the word that will sit at the FIFO
        // head after this edge. If the FIFO drains, the head keeps its
        // last value.
        head_load = 1'b0;
        head_d    = {out_instr_q, out_addr_q};
        if (accept && ((count_q == 3'd0) || (pop && count_q == 3'd1))) begin
            head_load = 1'b1;
            head_d    = {enc_word, tag};
        end else if (pop && count_q >= 3'd2) begin
            head_load = 1'b1;
            head_d    = fifo_mem[rd_ptr_inc];
        end
    end

    // ------------------------------------------------------------------
    // Storage (no reset needed; validity is tracked by count_q)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept)
            fifo_mem[wr_ptr_q] <= {enc_word, tag};
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= 2'd0;
            rd_ptr_q    <= 2'd0;
            count_q     <= 3'd0;
            ready_en_q  <= 1'b0;
            addr_q      <= 8'd0;
            out_instr_q <= 32'd0;
            out_addr_q  <= 8'd0;
            err_q       <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            count_q    <= count_d;
            addr_q     <= addr_d;
            err_q      <= err_d;
            if (accept)
                wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop)
                rd_ptr_q <= rd_ptr_inc;
            if (head_load) begin
                out_instr_q <= head_d[39:8];
                out_addr_q  <= head_d[7:0];
            end
        end
    end

    assign out_instr = out_instr_q;
    assign out_addr  = out_addr_q;
    assign err       = err_q;

endmodule
